ldpc_enc_ctrl: RTL and testbench

Control and sequencing wrapper around the team's `encode` LDPC generator-matrix datapath. It loads the K×N generator matrix row-by-row through a config handshake and gates encoding until the matrix is complete. It accepts info words on a valid/ready input stream, drives the encoder enable, and presents codewords on a valid/ready output stream with backpressure. It sits between the info-bit source (framer/FIFO) and the channel-side consumer.

---
 rtl/ldpc_pkg.sv | 17 +
 rtl/ldpc_enc_ctrl_encode.sv | 36 +++
 rtl/ldpc_enc_ctrl.sv | 137 +++++++++++++
 tb/tb_ldpc_enc_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ldpc_pkg.sv
// Shared constants for the LDPC encoder controller: state encoding, default
// code dimensions and the generator row offset helper.
package ldpc_pkg;

  localparam int N_DEF = 6;
  localparam int K_DEF = 3;

  localparam logic [1:0] ST_UNCFG   = 2'd0;
  localparam logic [1:0] ST_LOADING = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  // Bit offset of generator row j inside the flattened K*N matrix.
  function automatic int row_off(input int j, input int n);
    return j * n;
  endfunction

endpackage

// File: rtl/ldpc_enc_ctrl_encode.sv
// Generator-matrix LDPC encode datapath: registers the XOR of the selected
// generator rows whenever i_en is high, otherwise holds the last codeword.
module encode
  import ldpc_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [K-1:0]     i_bits,
  input  logic [K*N-1:0]   generator,
  output logic [N-1:0]     o_codeword
);

  logic [N-1:0] cw_d, cw_q;

  always_comb begin
    cw_d = cw_q;
    if (i_en) begin
      cw_d = '0;
      for (int j = 0; j < K; j++) begin
        if (i_bits[j]) cw_d = cw_d ^ generator[row_off(j, N) +: N];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cw_q <= '0;
    else     cw_q <= cw_d;
  end

  assign o_codeword = cw_q;

endmodule

// File: rtl/ldpc_enc_ctrl.sv
// LDPC encoder controller: sequential generator row loading, input/output
// valid/ready streams around the encode datapath. ENC_COUNT_EN adds enc_count.
//
// state      | meaning
// ST_UNCFG   | no matrix since reset, waiting for row 0
// ST_LOADING | rows being written sequentially, encoding gated
// ST_RUN     | matrix complete, encoding enabled
module ldpc_enc_ctrl
  import ldpc_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF
`ifdef ENC_COUNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [N-1:0]      cfg_row,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [K-1:0]      in_bits,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_codeword,
  output logic              gen_loaded
`ifdef ENC_COUNT_EN
  , output logic [CNT_W-1:0] enc_count
`endif
);

  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

  logic [1:0]       state_d, state_q;
  logic [IDX_W-1:0] row_idx_d, row_idx_q, wr_idx;
  logic [K*N-1:0]   gen_d, gen_q;
  logic             gen_loaded_d, gen_loaded_q;
  logic             out_valid_d, out_valid_q;
  logic             cfg_en_q;
  logic             cfg_hs, in_hs, out_hs;

  always_comb begin
    in_ready  = (state_q == ST_RUN) && (!out_valid_q || out_ready);
    cfg_ready = 1'b0;
    case (state_q)
      ST_UNCFG, ST_LOADING: cfg_ready = cfg_en_q;
      // Reconfig only with the output drained; pending input takes priority.
      ST_RUN:               cfg_ready = cfg_en_q && !out_valid_q && !in_valid;
      default:              cfg_ready = 1'b0;
    endcase
  end

  assign cfg_hs = cfg_valid && cfg_ready;
  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid_q && out_ready;
  assign wr_idx = (state_q == ST_RUN) ? '0 : row_idx_q;

  always_comb begin
    state_d      = state_q;
    row_idx_d    = row_idx_q;
    gen_d        = gen_q;
    gen_loaded_d = gen_loaded_q;
    if (state_q != ST_UNCFG && state_q != ST_LOADING && state_q != ST_RUN) begin
      state_d = ST_UNCFG;
    end
    if (cfg_hs) begin
      gen_d[row_off(int'(wr_idx), N) +: N] = cfg_row;
      if (wr_idx == LAST_IDX) begin
        row_idx_d    = '0;
        gen_loaded_d = 1'b1;
        state_d      = ST_RUN;
      end else begin
        row_idx_d    = wr_idx + IDX_W'(1);
        gen_loaded_d = 1'b0;
        state_d      = ST_LOADING;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (in_hs)       out_valid_d = 1'b1;
    else if (out_hs) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_UNCFG;
      row_idx_q    <= '0;
      gen_q        <= '0;
      gen_loaded_q <= 1'b0;
      out_valid_q  <= 1'b0;
      cfg_en_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_idx_q    <= row_idx_d;
      gen_q        <= gen_d;
      gen_loaded_q <= gen_loaded_d;
      out_valid_q  <= out_valid_d;
      cfg_en_q     <= 1'b1;
    end
  end

  encode #(.N(N), .K(K)) u_encode (
    .clk        (clk),
    .rst        (rst),
    .i_en       (in_hs),
    .i_bits     (in_bits),
    .generator  (gen_q),
    .o_codeword (out_codeword)
  );

  assign out_valid  = out_valid_q;
  assign gen_loaded = gen_loaded_q;

`ifdef ENC_COUNT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Only a RUN->LOADING reconfig clears; the post-reset load does not.
  always_comb begin
    cnt_d = cnt_q;
    if (cfg_hs && state_q == ST_RUN && state_d == ST_LOADING) cnt_d = '0;
    else if (out_hs)                                          cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign enc_count = cnt_q;
`endif

endmodule

// File: tb/tb_ldpc_enc_ctrl.sv
// Self-checking bench for ldpc_enc_ctrl (N=6, K=3); exercises enc_count when
// ENC_COUNT_EN is defined.
module tb_ldpc_enc_ctrl;

  localparam int N = 6;
  localparam int K = 3;
  localparam int CNT = 2;

  localparam logic [5:0] G0 = 6'b011001;
  localparam logic [5:0] G1 = 6'b101010;
  localparam logic [5:0] G2 = 6'b110100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [N-1:0] cfg_row = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [K-1:0] in_bits = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] out_codeword;
  logic         gen_loaded;
  logic [CNT-1:0] enc_count_w;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

`ifdef ENC_COUNT_EN
  ldpc_enc_ctrl #(.N(N), .K(K), .CNT_W(CNT)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_row(cfg_row),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .out_valid(out_valid), .out_ready(out_ready), .out_codeword(out_codeword),
    .gen_loaded(gen_loaded), .enc_count(enc_count_w));
`else
  ldpc_enc_ctrl #(.N(N), .K(K)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_row(cfg_row),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
    .out_valid(out_valid), .out_ready(out_ready), .out_codeword(out_codeword),
    .gen_loaded(gen_loaded));
  assign enc_count_w = '0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: rows held as an array, configuration progress as a row count.
  logic [N-1:0] m_g [K];
  bit   m_init = 0, m_started, m_run, m_ov;
  int   m_rows, m_cnt;
  logic [N-1:0] m_cw;
  bit   e_ir, e_cr, m_acc, m_ch, m_oh;

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1; m_started = 0; m_run = 0; m_ov = 0; m_rows = 0; m_cnt = 0; m_cw = '0;
      for (int j = 0; j < K; j++) m_g[j] = '0;
    end else if (m_init) begin
      e_ir  = m_run && (!m_ov || out_ready);
      e_cr  = m_started && (!m_run || (!m_ov && !in_valid));
      m_acc = in_valid && e_ir;
      m_ch  = cfg_valid && e_cr;
      m_oh  = m_ov && out_ready;
      if (m_oh) m_cnt = (m_cnt + 1) % (1 << CNT);
      if (m_acc) begin
        m_cw = '0;
        for (int j = 0; j < K; j++) if (in_bits[j]) m_cw = m_cw ^ m_g[j];
        m_ov = 1;
      end else if (m_oh) m_ov = 0;
      if (m_ch) begin
        if (m_run) begin
          if (K > 1) m_cnt = 0;
          m_run = 0; m_rows = 0;
        end
        m_g[m_rows] = cfg_row;
        m_rows++;
        if (m_rows == K) begin m_rows = 0; m_run = 1; end
      end
      m_started = 1;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready",     32'(in_ready),     32'(m_run && (!m_ov || out_ready)));
      chk("cfg_ready",    32'(cfg_ready),    32'(m_started && (!m_run || (!m_ov && !in_valid))));
      chk("gen_loaded",   32'(gen_loaded),   32'(m_run));
      chk("out_valid",    32'(out_valid),    32'(m_ov));
      chk("out_codeword", 32'(out_codeword), 32'(m_cw));
`ifdef ENC_COUNT_EN
      chk("enc_count",    32'(enc_count_w),  32'(m_cnt));
`endif
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input logic [N-1:0] row);
    bit ok = 0;
    cfg_valid = 1'b1;
    cfg_row   = row;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (cfg_ready) ok = 1;
      @(posedge clk); #1;
    end
    if (!ok) chk("cfg_timeout", 32'(0), 32'(1));
    cfg_valid = 1'b0;
  endtask

  initial begin
    step(); step();
    chk("rst_cfg_ready", 32'(cfg_ready), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_codeword",  32'(out_codeword), 32'(0));
    rst = 1'b0;

    // 1: load with input pending
    in_valid = 1'b1; in_bits = 3'b111;
    cfg_write(G0);
    chk("t1_in_ready_loading", 32'(in_ready), 32'(0));
    cfg_write(G1);
    chk("t1_gen_loaded_pre", 32'(gen_loaded), 32'(0));
    cfg_write(G2);
    in_valid = 1'b0;
    chk("t1_gen_loaded", 32'(gen_loaded), 32'(1));

    // 2: back-to-back words
    out_ready = 1'b1; in_valid = 1'b1; in_bits = 3'b011;
    step(); chk("t2_w0", 32'(out_codeword), 32'(6'b110011)); chk("t2_v0", 32'(out_valid), 32'(1));
    in_bits = 3'b111;
    step(); chk("t2_w1", 32'(out_codeword), 32'(6'b000111)); chk("t2_v1", 32'(out_valid), 32'(1));
    in_bits = 3'b000;
    step(); chk("t2_w2", 32'(out_codeword), 32'(6'b000000)); chk("t2_v2", 32'(out_valid), 32'(1));
    in_valid = 1'b0;
    step(); chk("t2_drain", 32'(out_valid), 32'(0));

    // 3: backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_bits = 3'b001;
    step();
    in_bits = 3'b010;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_hold_cw", 32'(out_codeword), 32'(6'b011001));
      chk("t3_hold_ir", 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1; #1;
    chk("t3_ir_release", 32'(in_ready), 32'(1));
    step(); chk("t3_next", 32'(out_codeword), 32'(6'b101010)); chk("t3_nv", 32'(out_valid), 32'(1));
    in_valid = 1'b0;
    step();

    // input beats a simultaneous row offer in RUN
    cfg_valid = 1'b1; cfg_row = 6'b111111; in_valid = 1'b1; in_bits = 3'b011; #1;
    chk("prio_cfg_ready", 32'(cfg_ready), 32'(0));
    step();
    cfg_valid = 1'b0; in_valid = 1'b0;
    step(); chk("prio_loaded", 32'(gen_loaded), 32'(1));

    // 4: reconfig
    cfg_write(6'b111111);
    chk("t4_gen_loaded", 32'(gen_loaded), 32'(0));
    in_valid = 1'b1; in_bits = 3'b001; #1;
    chk("t4_in_ready", 32'(in_ready), 32'(0));
    cfg_write(G1);
    cfg_write(G2);
    chk("t4_reloaded", 32'(gen_loaded), 32'(1));
    step(); chk("t4_cw", 32'(out_codeword), 32'(6'b111111));
    in_valid = 1'b0;
    step();

    // 5: reset mid-operation
    out_ready = 1'b0; in_valid = 1'b1; in_bits = 3'b001;
    step(); chk("t5_pending", 32'(out_valid), 32'(1));
    rst = 1'b1; in_valid = 1'b0;
    step(); chk("t5_ov", 32'(out_valid), 32'(0)); chk("t5_gl", 32'(gen_loaded), 32'(0));
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; in_bits = 3'b111;
    for (int i = 0; i < 3; i++) begin
      step(); chk("t5_no_accept", 32'(in_ready), 32'(0));
    end
    cfg_write(G0); cfg_write(G1); cfg_write(G2);
    step(); chk("t5_cw", 32'(out_codeword), 32'(6'b000111));
    in_valid = 1'b0;
    step();

`ifdef ENC_COUNT_EN
    // 6: codeword counter
    cfg_write(G0);
    chk("t6_clear", 32'(enc_count_w), 32'(0));
    cfg_write(G1); cfg_write(G2);
    in_valid = 1'b1; in_bits = 3'b001;
    step();
    for (int i = 0; i < 5; i++) begin
      logic [1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      if (i == 4) in_valid = 1'b0;
      step();
      chk("t6_count", 32'(enc_count_w), 32'(exp_seq[i]));
    end
    cfg_write(6'b111111);
    chk("t6_reconf_clear", 32'(enc_count_w), 32'(0));
    cfg_write(G1); cfg_write(G2);
`endif

    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
